// File: rtl/sys_defs.sv
// sys_defs: shared types and constants for the load memory controller.
//   BUS_COMMAND : memory bus command encoding
//   MEM_SIZE    : access size encoding (mem_size[1:0])
//   LMC_STATE   : controller FSM states
//   LINE_W      : memory line width in bits
//   line_base() : 8-byte aligned base of a byte address
package sys_defs;

  localparam int LINE_W = 64;

  typedef enum logic [1:0] {
    BUS_NONE  = 2'h0,
    BUS_LOAD  = 2'h1,
    BUS_STORE = 2'h2
  } BUS_COMMAND;

  typedef enum logic [1:0] {
    BYTE   = 2'h0,
    HALF   = 2'h1,
    WORD   = 2'h2,
    DOUBLE = 2'h3
  } MEM_SIZE;

  typedef enum logic [2:0] {
    IDLE  = 3'h0,
    REQ   = 3'h1,
    WAIT  = 3'h2,
    DONE  = 3'h3,
    DRAIN = 3'h4
  } LMC_STATE;

  function automatic logic [31:0] line_base(input logic [31:0] a);
    return {a[31:3], 3'b000};
  endfunction

endpackage

// File: rtl/load_data_align.sv
// load_data_align: combinational extraction of a byte/half/word from a 64-bit
// line at a byte offset, sign- or zero-extended to 32 bits.
//   line_i   in  64  memory line
//   offset_i in  3   byte offset within the line
//   size_i   in  3   [1:0] BYTE/HALF/WORD, [2] 1 = zero-extend
//   data_o   out 32  extended value
// Bytes past the end of the line read as zero (no split access).
module load_data_align (
  input  logic [63:0] line_i,
  input  logic [2:0]  offset_i,
  input  logic [2:0]  size_i,
  output logic [31:0] data_o
);
  import sys_defs::*;

  logic [63:0] shifted_s;
  logic        unused_s;

  // Zero-fill shift means misaligned upper bytes fall off as 0.
  assign shifted_s = line_i >> {offset_i, 3'b000};
  assign unused_s  = ^shifted_s[63:32];

  // Size select and extension.
  always_comb begin
    data_o = 32'h0000_0000;
    case (MEM_SIZE'(size_i[1:0]))
      BYTE:    data_o = {{24{~size_i[2] & shifted_s[7]}},  shifted_s[7:0]};
      HALF:    data_o = {{16{~size_i[2] & shifted_s[15]}}, shifted_s[15:0]};
      default: data_o = shifted_s[31:0];
    endcase
  end

endmodule

// File: rtl/load_mem_ctrl.sv
// load_mem_ctrl: serves the load buffer's single outstanding read by issuing a
// 64-bit BUS_LOAD, matching the returned tag and returning the extracted value
// with a one-cycle cache_valid pulse.
// Ports:
//   clock, reset (sync, active-low)
//   rd_cache/addr/mem_size : load request from the load buffer
//   squash                 : abandon the current load
//   mem_busy               : bus taken by a higher-priority requester
//   st_valid/st_addr       : committed-store snoop (line reuse only)
//   proc2mem_command/addr/size : bus request
//   mem2proc_response/data/tag : bus acceptance tag and returned data
//   cache_valid/cache_data     : response to the load buffer
// Optional feature: define LMC_LINE_REUSE_EN to keep the last returned line and
// answer repeat loads to it in one cycle without a bus access.
module load_mem_ctrl #(
  parameter int TAG_W  = 4,
  parameter int LINE_W = 64
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              rd_cache,
  input  logic [31:0]       addr,
  input  logic [2:0]        mem_size,
  input  logic              squash,
  input  logic              mem_busy,
  input  logic              st_valid,
  input  logic [31:0]       st_addr,
  output logic [1:0]        proc2mem_command,
  output logic [31:0]       proc2mem_addr,
  output logic [1:0]        proc2mem_size,
  input  logic [TAG_W-1:0]  mem2proc_response,
  input  logic [LINE_W-1:0] mem2proc_data,
  input  logic [TAG_W-1:0]  mem2proc_tag,
  output logic              cache_valid,
  output logic [31:0]       cache_data
);
  import sys_defs::*;

  LMC_STATE         state_q, state_d;
  logic [31:0]      addr_q, addr_d;
  logic [2:0]       size_q, size_d;
  logic [TAG_W-1:0] tag_q, tag_d;
  logic [31:0]      data_q, data_d;

  logic [31:0]      wait_data_s;
  logic             tag_hit_s;
  logic             line_hit_s;
  logic [31:0]      hit_data_s;

  // Tag 0 means "no transaction", so a zero saved tag never matches.
  assign tag_hit_s = (tag_q != {TAG_W{1'b0}}) && (mem2proc_tag == tag_q);

  load_data_align u_align (
    .line_i   (mem2proc_data),
    .offset_i (addr_q[2:0]),
    .size_i   (size_q),
    .data_o   (wait_data_s)
  );

`ifdef LMC_LINE_REUSE_EN
  logic        line_vld_q, line_vld_d;
  logic [28:0] line_tag_q, line_tag_d;
  logic [63:0] line_data_q, line_data_d;
  logic        st_kill_s;
  logic        unused_st_s;

  // A store to the held line beats a hit in the same cycle.
  assign st_kill_s   = st_valid && (st_addr[31:3] == line_tag_q);
  assign line_hit_s  = line_vld_q && (addr[31:3] == line_tag_q) && !st_kill_s;
  assign unused_st_s = ^st_addr[2:0];

  load_data_align u_hit_align (
    .line_i   (line_data_q),
    .offset_i (addr[2:0]),
    .size_i   (mem_size),
    .data_o   (hit_data_s)
  );

  // Line register: fill on every matched return, invalidate on store or squash.
  always_comb begin
    line_vld_d  = line_vld_q;
    line_tag_d  = line_tag_q;
    line_data_d = line_data_q;
    if (state_q == WAIT && tag_hit_s) begin
      line_vld_d  = 1'b1;
      line_tag_d  = addr_q[31:3];
      line_data_d = mem2proc_data;
    end else begin
      line_vld_d  = line_vld_q;
    end
    if (squash || (st_valid && st_addr[31:3] == line_tag_d)) begin
      line_vld_d = 1'b0;
    end else begin
      line_vld_d = line_vld_d;
    end
  end

  // Line register state.
  always_ff @(posedge clock) begin
    if (!reset) begin
      line_vld_q  <= 1'b0;
      line_tag_q  <= 29'h0;
      line_data_q <= 64'h0;
    end else begin
      line_vld_q  <= line_vld_d;
      line_tag_q  <= line_tag_d;
      line_data_q <= line_data_d;
    end
  end
`else
  logic unused_st_s;

  assign line_hit_s  = 1'b0;
  assign hit_data_s  = 32'h0000_0000;
  assign unused_st_s = st_valid ^ (^st_addr);
`endif

  // Next-state and bus/response outputs.
  always_comb begin
    state_d          = state_q;
    addr_d           = addr_q;
    size_d           = size_q;
    tag_d            = tag_q;
    data_d           = data_q;
    proc2mem_command = BUS_NONE;
    proc2mem_addr    = 32'h0000_0000;
    proc2mem_size    = 2'b00;
    cache_valid      = 1'b0;
    cache_data       = 32'h0000_0000;
    case (state_q)
      IDLE: begin
        if (rd_cache && !squash) begin
          addr_d = addr;
          size_d = mem_size;
          if (line_hit_s) begin
            data_d  = hit_data_s;
            state_d = DONE;
          end else begin
            state_d = REQ;
          end
        end else begin
          state_d = IDLE;
        end
      end
      REQ: begin
        if (squash) begin
          state_d = IDLE;
        end else if (mem_busy) begin
          state_d = REQ;
        end else begin
          proc2mem_command = BUS_LOAD;
          proc2mem_addr    = line_base(addr_q);
          proc2mem_size    = DOUBLE;
          if (mem2proc_response != {TAG_W{1'b0}}) begin
            tag_d   = mem2proc_response;
            state_d = WAIT;
          end else begin
            state_d = REQ;
          end
        end
      end
      WAIT: begin
        if (tag_hit_s) begin
          data_d  = wait_data_s;
          state_d = squash ? IDLE : DONE;
        end else if (squash) begin
          // Tag is still in flight; it must be consumed before reuse.
          state_d = DRAIN;
        end else begin
          state_d = WAIT;
        end
      end
      DONE: begin
        cache_valid = !squash;
        cache_data  = squash ? 32'h0000_0000 : data_q;
        state_d     = IDLE;
      end
      DRAIN: begin
        if (tag_hit_s) begin
          state_d = IDLE;
        end else begin
          state_d = DRAIN;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Controller state.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q <= IDLE;
      addr_q  <= 32'h0000_0000;
      size_q  <= 3'b000;
      tag_q   <= {TAG_W{1'b0}};
      data_q  <= 32'h0000_0000;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      size_q  <= size_d;
      tag_q   <= tag_d;
      data_q  <= data_d;
    end
  end

endmodule
